// File: rtl/quad_pkg.sv
// Shared quadrature types: the four encoder phases in {a,b} order and the
// rule that classifies a move between two phases as forward, reverse or illegal.
package quad_pkg;

  typedef enum logic [1:0] {
    P00 = 2'b00,
    P01 = 2'b01,
    P11 = 2'b11,
    P10 = 2'b10
  } phase_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_FWD,
    DIR_REV,
    DIR_ILLEGAL
  } dir_t;

  // Position of a phase along the forward rotation P00->P01->P11->P10.
  function automatic logic [1:0] phase_index(input phase_t p);
    logic [1:0] idx;
    case (p)
      P00:     idx = 2'd0;
      P01:     idx = 2'd1;
      P11:     idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // A quarter turn either way is a step; a half turn means both bits flipped.
  function automatic dir_t classify(input phase_t from, input phase_t to);
    logic [1:0] delta;
    dir_t       dir;
    delta = phase_index(to) - phase_index(from);
    case (delta)
      2'd0:    dir = DIR_NONE;
      2'd1:    dir = DIR_FWD;
      2'd3:    dir = DIR_REV;
      default: dir = DIR_ILLEGAL;
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/debouncer.sv
// Two-flop synchronizer followed by a stability filter: a new bus value is
// accepted only after it has been seen unchanged for DEBOUNCE consecutive cycles.
module debouncer #(
  parameter int DEBOUNCE = 4,
  parameter int W        = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] stable,
  output logic         accept
);

  localparam int            CW     = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DB_LEN = CW'(DEBOUNCE);

  logic [W-1:0]  sync1;
  logic [W-1:0]  sync2;
  logic [W-1:0]  cand;
  logic [CW-1:0] run_len;
  logic [CW-1:0] next_len;
  logic          stable_valid;
  logic          fresh;

  // A candidate run restarts whenever the synchronized value changes.
  always_comb begin
    fresh    = (run_len == '0) || (sync2 != cand);
    next_len = fresh ? CW'(1) : run_len + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1        <= '0;
      sync2        <= '0;
      cand         <= '0;
      stable       <= '0;
      stable_valid <= 1'b0;
      run_len      <= '0;
      accept       <= 1'b0;
    end else begin
      sync1  <= din;
      sync2  <= sync1;
      accept <= 1'b0;
      if (stable_valid && (sync2 == stable)) begin
        run_len <= '0;
      end else if (next_len >= DB_LEN) begin
        stable       <= sync2;
        stable_valid <= 1'b1;
        accept       <= 1'b1;
        run_len      <= '0;
      end else begin
        cand    <= sync2;
        run_len <= next_len;
      end
    end
  end

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature encoder decoder: debounced A/B phases drive a saturating
// position counter with per-step pulses and illegal-transition error flags.
module quadrature_decoder
  import quad_pkg::*;
#(
  parameter int N        = 8,
  parameter int DEBOUNCE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         a,
  input  logic         b,
  output logic [N-1:0] count,
  output logic         step_up,
  output logic         step_down,
  output logic         err,
  output logic         err_sticky
);

  localparam logic [N-1:0] COUNT_MAX = '1;

  logic [1:0] deb_value;
  logic       deb_accept;
  phase_t     new_phase;
  phase_t     phase;
  logic       phase_valid;
  dir_t       dir;

  debouncer #(
    .DEBOUNCE(DEBOUNCE),
    .W       (2)
  ) u_debouncer (
    .clk   (clk),
    .rst   (rst),
    .din   ({a, b}),
    .stable(deb_value),
    .accept(deb_accept)
  );

  always_comb begin
    new_phase = phase_t'(deb_value);
    dir       = classify(phase, new_phase);
  end

  // The first accepted phase after reset only seeds the tracker.
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      step_up     <= 1'b0;
      step_down   <= 1'b0;
      err         <= 1'b0;
      err_sticky  <= 1'b0;
      phase       <= P00;
      phase_valid <= 1'b0;
    end else begin
      step_up   <= 1'b0;
      step_down <= 1'b0;
      err       <= 1'b0;
      if (deb_accept) begin
        phase       <= new_phase;
        phase_valid <= 1'b1;
        if (phase_valid) begin
          case (dir)
            DIR_FWD: begin
              if (ena) begin
                step_up <= 1'b1;
                if (count != COUNT_MAX) count <= count + 1'b1;
              end
            end
            DIR_REV: begin
              if (ena) begin
                step_down <= 1'b1;
                if (count != '0) count <= count - 1'b1;
              end
            end
            DIR_ILLEGAL: begin
              err        <= 1'b1;
              err_sticky <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Self-checking bench for quadrature_decoder: a sliding-window reference model
// checked every cycle, plus table vectors and hand-written corner sequences.
module tb_quadrature_decoder;

  localparam int N  = 8;
  localparam int DB = 4;
  localparam int CMAX = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ena = 1'b1;
  logic         a   = 1'b0;
  logic         b   = 1'b0;
  logic [N-1:0] count;
  logic         step_up, step_down, err, err_sticky;

  int checks = 0;
  int errors = 0;
  int n_up, n_down, n_err;

  always #5 clk = ~clk;

  quadrature_decoder #(.N(N), .DEBOUNCE(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .a         (a),
    .b         (b),
    .count     (count),
    .step_up   (step_up),
    .step_down (step_down),
    .err       (err),
    .err_sticky(err_sticky)
  );

  // Reference model: a value is accepted once the last DB synchronized samples
  // all agree and differ from the debounced phase; decode lands one edge later.
  logic [1:0] m_sync1, m_sync2, m_dphase, m_pend_val, m_phase;
  logic [1:0] m_win[$];
  bit m_seen, m_pend, m_valid, m_up, m_down, m_err, m_sticky;
  bit model_live = 0;
  int m_count;

  function automatic int ring_pos(input logic [1:0] p);
    logic [1:0] order [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    for (int i = 0; i < 4; i++) if (order[i] == p) return i;
    return 0;
  endfunction

  function automatic logic [1:0] fwd_next(input logic [1:0] p);
    logic [1:0] order [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    return order[(ring_pos(p) + 1) % 4];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_sync1 = 0; m_sync2 = 0; m_win.delete();
      m_seen = 0; m_pend = 0; m_valid = 0; m_dphase = 0; m_phase = 0;
      m_up = 0; m_down = 0; m_err = 0; m_sticky = 0; m_count = 0;
      model_live = 1;
    end else begin
      m_up = 0; m_down = 0; m_err = 0;
      if (m_pend) begin
        if (m_valid) begin
          int st;
          st = (ring_pos(m_pend_val) - ring_pos(m_phase) + 4) % 4;
          if (st == 1 && ena) begin
            m_up = 1;
            if (m_count < CMAX) m_count++;
          end else if (st == 3 && ena) begin
            m_down = 1;
            if (m_count > 0) m_count--;
          end else if (st == 2) begin
            m_err = 1; m_sticky = 1;
          end
        end
        m_valid = 1; m_phase = m_pend_val; m_pend = 0;
      end
      m_win.push_back(m_sync2);
      if (m_win.size() > DB) void'(m_win.pop_front());
      m_sync2 = m_sync1;
      m_sync1 = {a, b};
      if (m_win.size() == DB) begin
        bit same;
        same = 1;
        foreach (m_win[i]) if (m_win[i] != m_win[0]) same = 0;
        if (same && (!m_seen || m_win[0] != m_dphase)) begin
          m_pend = 1; m_pend_val = m_win[0]; m_dphase = m_win[0]; m_seen = 1;
        end
      end
    end
  end

  task automatic compare(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput();
    if (model_live) begin
      compare("model_count", int'(count), m_count);
      compare("model_step_up", int'(step_up), int'(m_up));
      compare("model_step_down", int'(step_down), int'(m_down));
      compare("model_err", int'(err), int'(m_err));
      compare("model_err_sticky", int'(err_sticky), int'(m_sticky));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    checkOutput();
    n_up   += int'(step_up);
    n_down += int'(step_down);
    n_err  += int'(err);
  endtask

  task automatic applyStimulus(input logic na, input logic nb, input logic nena, input int hold);
    a = na; b = nb; ena = nena;
    repeat (hold) tick();
  endtask

  task automatic clearTally();
    n_up = 0; n_down = 0; n_err = 0;
  endtask

  typedef struct {
    logic a;
    logic b;
    logic ena;
    int   hold;
    int   exp_count;
    int   exp_up;
    int   exp_down;
    int   exp_err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [1:0] cur;
    int lat;
    int base;

    vecs.push_back('{1'b0, 1'b0, 1'b1, 10, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 10, 1, 1, 0, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 10, 2, 1, 0, 0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 10, 3, 1, 0, 0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 10, 4, 1, 0, 0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 10, 3, 0, 1, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 10, 2, 0, 1, 0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 10, 1, 0, 1, 0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 10, 0, 0, 1, 0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 10, 0, 0, 1, 0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 10, 0, 0, 0, 1});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 10, 1, 1, 0, 0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 10, 1, 0, 0, 0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 10, 1, 0, 0, 0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 10, 1, 0, 0, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 10, 2, 1, 0, 0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 10, 2, 0, 0, 1});

    clearTally();
    rst = 1'b1; a = 1'b0; b = 1'b0; ena = 1'b1;
    repeat (2) tick();
    compare("reset_count", int'(count), 0);
    compare("reset_pulses", int'(step_up) + int'(step_down) + int'(err), 0);
    compare("reset_err_sticky", int'(err_sticky), 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      clearTally();
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].ena, vecs[i].hold);
      compare($sformatf("vec%0d_count", i), int'(count), vecs[i].exp_count);
      compare($sformatf("vec%0d_up", i), n_up, vecs[i].exp_up);
      compare($sformatf("vec%0d_down", i), n_down, vecs[i].exp_down);
      compare($sformatf("vec%0d_err", i), n_err, vecs[i].exp_err);
    end
    compare("sticky_after_illegal", int'(err_sticky), 1);

    // Forward step latency from 00 to 01, measured in clock edges.
    lat = -1;
    a = 1'b0; b = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (step_up && lat < 0) lat = e;
    end
    compare("latency_fwd_edges", lat, DB + 3);
    compare("latency_count", int'(count), 3);

    // A three-cycle glitch on a is rejected.
    clearTally();
    applyStimulus(1'b1, 1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b1, 1'b1, 15);
    compare("glitch_pulses", n_up + n_down + n_err, 0);
    compare("glitch_count", int'(count), 3);

    // Reset in the middle of a pending step drops it and clears err_sticky.
    clearTally();
    applyStimulus(1'b1, 1'b1, 1'b1, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 12);
    compare("midrst_count", int'(count), 0);
    compare("midrst_pulses", n_up + n_down, 0);
    compare("midrst_sticky", int'(err_sticky), 0);

    // Drive to the top and push one more forward step.
    cur = 2'b11;
    for (int s = 0; s < CMAX; s++) begin
      cur = fwd_next(cur);
      applyStimulus(cur[1], cur[0], 1'b1, 6);
    end
    applyStimulus(cur[1], cur[0], 1'b1, 10);
    compare("sat_high_reach", int'(count), CMAX);
    clearTally();
    cur = fwd_next(cur);
    applyStimulus(cur[1], cur[0], 1'b1, 10);
    compare("sat_high_up", n_up, 1);
    compare("sat_high_count", int'(count), CMAX);

    // Randomized traffic against the reference model.
    base = checks;
    for (int r = 0; r < 400; r++) begin
      logic [1:0] v;
      v = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      applyStimulus(v[1], v[0], ($urandom_range(0, 3) != 0), $urandom_range(1, 8));
    end
    if (checks == base) compare("random_checks_ran", 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quadrature_decoder.md
QUADRATURE_DECODER -- requirements
Module: quadrature_decoder

Interface
REQ-001 SHALL have parameter N, default 8, width of the position count.
REQ-002 SHALL have parameter DEBOUNCE, default 4, consecutive stable cycles required to accept a new A/B value (min 1).
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ena  input  1  count enable; low holds count and suppresses step pulses.
REQ-006 SHALL have port a  input  1  encoder channel A, asynchronous.
REQ-007 SHALL have port b  input  1  encoder channel B, asynchronous.
REQ-008 SHALL have port count  output  N  position, unsigned.
REQ-009 SHALL have port step_up  output  1  one-cycle pulse per accepted forward step.
REQ-010 SHALL have port step_down  output  1  one-cycle pulse per accepted reverse step.
REQ-011 SHALL have port err  output  1  one-cycle pulse per illegal two-bit transition.
REQ-012 SHALL have port err_sticky  output  1  set by any err, cleared only by rst.

Function
REQ-013 SHALL pass a and b each through a two-flop synchronizer before any other use.
REQ-014 SHALL accept a new synchronized {a,b} value into the debounced phase only after it differs from the current phase for DEBOUNCE consecutive cycles; any reversion restarts the stability count.
REQ-015 SHALL treat pulses shorter than DEBOUNCE cycles as noise: no phase, count or pulse change.
REQ-016 SHALL use phases P00, P01, P11, P10 (encoding {a,b}); forward order P00->P01->P11->P10->P00, reverse is the opposite order.
REQ-017 SHALL classify each accepted phase change as forward, reverse, or illegal (both bits changed).
REQ-018 SHALL, on an accepted forward change with ena high, assert step_up for exactly one cycle and increment count.
REQ-019 SHALL, on an accepted reverse change with ena high, assert step_down for exactly one cycle and decrement count.
REQ-020 SHALL saturate count at 0 and 2^N-1 (no wrap); the step pulse is still asserted when saturated.
REQ-021 SHALL, on an illegal change, pulse err for one cycle, set err_sticky, leave count unchanged, and adopt the new phase; err is independent of ena.
REQ-022 SHALL, with ena low, still track and adopt phase changes but neither change count nor pulse step_up/step_down.
REQ-023 SHALL never assert step_up and step_down in the same cycle.
REQ-024 SHALL produce count/pulse updates DEBOUNCE+3 clock edges after a stable input change (2 sync, DEBOUNCE debounce, 1 decode/register).
REQ-025 SHALL take the first debounced value accepted after reset as the initial phase, without step or err.

Reset
REQ-026 SHALL on rst clear count to 0, step_up, step_down, err, err_sticky to 0.
REQ-027 SHALL on rst clear synchronizer flops, debounce counter, and the phase-valid flag, regardless of activity in progress.
REQ-028 SHALL treat rst asserted mid-step as dropping that step entirely.

Structure
REQ-029 SHALL place phase_t enum (P00, P01, P11, P10) and a direction-classification function in shared package quad_pkg.
REQ-030 SHALL implement the synchronizer plus stability counter as sub-module debouncer (parameter DEBOUNCE), instantiated once on the 2-bit {a,b} bus.
REQ-031 SHALL keep decode, saturation, and err logic in quadrature_decoder itself.

Verification (N=8, DEBOUNCE=4)
REQ-032 SHALL check: rst for 2 cycles with a=b=0 -> count=0, all pulses 0, err_sticky=0.
REQ-033 SHALL check: four forward changes 00->01->11->10->00, each held 10 cycles -> four step_up pulses, each 7 edges after its input change; count=4.
REQ-034 SHALL check: from count=0, one reverse change 00->10 -> step_down pulses once, count stays 0; from count=255 one forward step -> step_up pulses, count stays 255.
REQ-035 SHALL check: a glitched high for 3 cycles then low -> no pulse, count unchanged.
REQ-036 SHALL check: 00->11 held 10 cycles -> err one cycle, err_sticky=1 until rst, count unchanged; a following 11->10 counts as forward (+1).
REQ-037 SHALL check: ena=0 during three forward steps, then ena=1 with one forward step -> count increases by exactly 1 total.
